// File: rtl/fir_tdm_multi.sv
// Time-multiplexed N_CH-channel FIR with one shared multiplier; accepts a frame only in IDLE,
// result pulses out_valid N_CH*N_TAPS+2 cycles after the handshake, round-half-up + saturate.
module fir_tdm_multi #(
  parameter int WD_IN  = 24,
  parameter int WD_OUT = 24,
  parameter int CO_WD  = 24,
  parameter int N_TAPS = 40,
  parameter int N_CH   = 2,
  parameter int FRAC   = 23
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CH*WD_IN-1:0]      in_data,
  input  logic                       bypass,
  input  logic                       coef_we,
  input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
  input  logic [CO_WD-1:0]           coef_data,
  output logic                       out_valid,
  output logic [N_CH*WD_OUT-1:0]     out_data,
  output logic                       busy
);

  localparam int AW    = $clog2(N_TAPS);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int P_W   = WD_IN + CO_WD;
  localparam int ACC_W = P_W + AW;

  localparam logic [AW-1:0]          TAP_LAST = AW'(N_TAPS - 1);
  localparam logic [CW-1:0]          CH_LAST  = CW'(N_CH - 1);
  localparam logic [CO_WD-1:0]       CO_ONE   = (FRAC >= CO_WD - 1) ?
                                                {1'b0, {(CO_WD-1){1'b1}}} : (CO_WD'(1) << FRAC);
  localparam logic signed [ACC_W:0]  RND      = (FRAC > 0) ? ((ACC_W+1)'(1) << (FRAC - 1)) : '0;
  localparam logic signed [ACC_W:0]  OUT_MAX  = {{(ACC_W+2-WD_OUT){1'b0}}, {(WD_OUT-1){1'b1}}};
  localparam logic signed [ACC_W:0]  OUT_MIN  = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

  state_t state, state_nx;

  logic signed [WD_IN-1:0]  dl   [N_CH][N_TAPS];
  logic signed [CO_WD-1:0]  coef [N_TAPS];
  logic signed [ACC_W-1:0]  acc     [N_CH];
  logic signed [ACC_W-1:0]  acc_fin [N_CH];

  logic [AW-1:0]            wptr, rd_ptr, tap_idx;
  logic [CW-1:0]            ch_idx, prod_ch;
  logic signed [P_W-1:0]    prod_q;
  logic                     prod_vld;
  logic                     byp_q;
  logic [N_CH*WD_IN-1:0]    frame_q;
  logic                     accept, mac_last, addr_ok;

  assign accept   = in_valid && (state == IDLE);
  assign mac_last = (ch_idx == CH_LAST) && (tap_idx == TAP_LAST);
  assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(N_TAPS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (in_valid) state_nx = MAC;
      MAC:     if (mac_last) state_nx = FLUSH;
      FLUSH:   state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Circular delay lines: newest sample lands at wptr, which then moves down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < N_TAPS; k++)
          dl[c][k] <= '0;
      wptr    <= '0;
      byp_q   <= 1'b0;
      frame_q <= '0;
    end else if (accept) begin
      for (int c = 0; c < N_CH; c++)
        dl[c][wptr] <= in_data[c*WD_IN +: WD_IN];
      wptr    <= (wptr == '0) ? TAP_LAST : wptr - 1'b1;
      byp_q   <= bypass;
      frame_q <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++)
        coef[k] <= (k == 0) ? CO_ONE : '0;
    end else if (coef_we && (state == IDLE) && addr_ok) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      tap_idx  <= '0;
      ch_idx   <= '0;
      prod_q   <= '0;
      prod_ch  <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= 1'b0;
      if (accept) begin
        rd_ptr  <= wptr;
        tap_idx <= '0;
        ch_idx  <= '0;
      end else if (state == MAC) begin
        prod_q   <= P_W'(dl[ch_idx][rd_ptr]) * P_W'(coef[tap_idx]);
        prod_ch  <= ch_idx;
        prod_vld <= 1'b1;
        rd_ptr   <= (rd_ptr == TAP_LAST) ? '0 : rd_ptr + 1'b1;
        if (tap_idx == TAP_LAST) begin
          tap_idx <= '0;
          ch_idx  <= ch_idx + 1'b1;
        end else begin
          tap_idx <= tap_idx + 1'b1;
        end
      end
    end
  end

  // acc_fin folds in the pending product so FLUSH can produce the result directly.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      acc_fin[c] = acc[c];
      if (prod_vld && (prod_ch == CW'(c)))
        acc_fin[c] = acc[c] + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++)
        acc[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        acc[c] <= accept ? '0 : acc_fin[c];
    end
  end

  function automatic logic [WD_OUT-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + RND;
    s = s >>> FRAC;
    if (s > OUT_MAX)      return OUT_MAX[WD_OUT-1:0];
    else if (s < OUT_MIN) return OUT_MIN[WD_OUT-1:0];
    else                  return s[WD_OUT-1:0];
  endfunction

  function automatic logic [WD_OUT-1:0] ext(input logic signed [WD_IN-1:0] v);
    return WD_OUT'(v);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == FLUSH);
      if (state == FLUSH) begin
        for (int c = 0; c < N_CH; c++)
          out_data[c*WD_OUT +: WD_OUT] <= byp_q ? ext(frame_q[c*WD_IN +: WD_IN])
                                                : rnd_sat(acc_fin[c]);
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_multi.sv
// Bench for fir_tdm_multi: table-driven vectors plus reference-model scoreboard sequences.
module tb_fir_tdm_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        bypass;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [23:0] coef_data;
  logic        out_valid;
  logic [47:0] out_data;
  logic        busy;

  fir_tdm_multi dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [47:0] exp_q[$];
  longint hist[2][40];
  longint mcoef[40];
  bit tbl_mode = 1'b0;
  logic [47:0] tbl_exp;
  logic [47:0] mon_e;
  int hs_cyc = 0;
  int acc_cnt = 0;
  int acc_cyc[$];
  int ov_cnt = 0;
  bit rdy_chk = 1'b0;

  typedef struct {
    bit          rst;
    bit          ld;
    logic [23:0] c0, c1, d0, d1;
    bit          byp;
    logic [23:0] e0, e1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void mdl_reset();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 40; k++)
        hist[c][k] = 0;
    for (int k = 0; k < 40; k++) mcoef[k] = 0;
    mcoef[0] = 64'sd8388607;
  endfunction

  // Shift-register reference: hist[c][0] is the newest sample.
  function automatic logic [23:0] mdl_ch(input int c, input logic byp, input logic [23:0] s);
    longint acc, r;
    for (int k = 39; k > 0; k--) hist[c][k] = hist[c][k-1];
    hist[c][0] = longint'($signed(s));
    if (byp) return s;
    acc = 0;
    for (int k = 0; k < 40; k++) acc += hist[c][k] * mcoef[k];
    r = (acc + 64'sd4194304) >>> 23;
    if (r > 64'sd8388607)  r = 64'sd8388607;
    if (r < -64'sd8388608) r = -64'sd8388608;
    return r[23:0];
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (rdy_chk) begin
        chk("ready_after_out", {63'd0, in_ready}, 64'd1);
        rdy_chk = 1'b0;
      end
      if (in_valid && in_ready) begin
        mon_e = {mdl_ch(1, bypass, in_data[47:24]), mdl_ch(0, bypass, in_data[23:0])};
        if (tbl_mode) mon_e = tbl_exp;
        exp_q.push_back(mon_e);
        hs_cyc = cyc;
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      if (out_valid) begin
        ov_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid: got out_data %h with nothing expected", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_ch0", {40'd0, out_data[23:0]}, {40'd0, mon_e[23:0]});
          chk("out_ch1", {40'd0, out_data[47:24]}, {40'd0, mon_e[47:24]});
          chk("latency", 64'(cyc - hs_cyc), 64'd82);
        end
        rdy_chk = 1'b1;
      end
    end
  end

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {16'd0, out_data}, 64'd0);
    exp_q.delete();
    mdl_reset();
    rdy_chk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wcoef(input logic [5:0] a, input logic [23:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    @(posedge clk);
    #1 coef_we = 1'b0;
    mcoef[a] = longint'($signed(v));
  endtask

  task automatic send(input logic [23:0] d0, input logic [23:0] d1, input logic byp);
    int n;
    in_valid = 1'b1;
    in_data  = {d1, d0};
    bypass   = byp;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed %b", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  int   ov_before;

  initial begin
    in_valid = 1'b0; in_data = '0; bypass = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    reset_n = 1'b1;

    vecs[0] = '{1, 0, 24'h000000, 24'h000000, 24'h100000, 24'hF00000, 0, 24'h100000, 24'hF00000};
    vecs[1] = '{1, 1, 24'h400000, 24'h200000, 24'h200000, 24'h200000, 0, 24'h100000, 24'h100000};
    vecs[2] = '{0, 0, 24'h000000, 24'h000000, 24'h200000, 24'h200000, 0, 24'h180000, 24'h180000};
    vecs[3] = '{1, 1, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 0, 24'h7FFFFE, 24'h800001};
    vecs[4] = '{0, 0, 24'h000000, 24'h000000, 24'h7FFFFF, 24'h800000, 0, 24'h7FFFFF, 24'h800000};
    vecs[5] = '{1, 1, 24'h000001, 24'h000000, 24'h400000, 24'hBFFFFF, 0, 24'h000001, 24'hFFFFFF};
    vecs[6] = '{1, 1, 24'h000000, 24'h400000, 24'h123456, 24'hABCDEF, 1, 24'h123456, 24'hABCDEF};
    vecs[7] = '{0, 0, 24'h000000, 24'h000000, 24'h7FFFFF, 24'h7FFFFF, 0, 24'h091A2B, 24'hD5E6F8};

    do_reset();

    tbl_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].ld) begin
        wcoef(6'd0, vecs[i].c0);
        wcoef(6'd1, vecs[i].c1);
      end
      tbl_exp = {vecs[i].e1, vecs[i].e0};
      send(vecs[i].d0, vecs[i].d1, vecs[i].byp);
      drain();
    end
    tbl_mode = 1'b0;

    // in_valid held high; a coefficient write while busy must be dropped.
    do_reset();
    acc_cnt = 0;
    acc_cyc.delete();
    in_valid = 1'b1;
    bypass   = 1'b0;
    for (int i = 0; i < 249; i++) begin
      in_data = {24'(-i * 7919), 24'(i * 40503)};
      if (i == 10) begin
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 24'h000000;
      end else begin
        coef_we = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    drain();
    chk("accept_count", 64'(acc_cnt), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("accept_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd83);
      chk("accept_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd83);
    end

    // Only the oldest tap is non-zero: exercises the delay-line wrap.
    do_reset();
    wcoef(6'd0, 24'h000000);
    wcoef(6'd39, 24'h7FFFFF);
    for (int n = 0; n < 100; n++) send(24'(n), 24'(-n), 1'b0);
    drain();

    // Reset forty cycles into MAC.
    do_reset();
    send(24'h200000, 24'h300000, 1'b0);
    repeat (39) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_data", {16'd0, out_data}, 64'd0);
    exp_q.delete();
    mdl_reset();
    rdy_chk = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    ov_before = ov_cnt;
    repeat (100) @(posedge clk);
    #1;
    chk("midrst_no_out_valid", 64'(ov_cnt - ov_before), 64'd0);
    wcoef(6'd1, 24'h7FFFFF);
    send(24'h100000, 24'hF00000, 1'b0);
    drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
